// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiplier and restoring
// divider behind a start/busy/done handshake; divide special cases finish in one cycle.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic              rneg_q;
    logic [2*XLEN-1:0] acc_q;
    logic [2*XLEN-1:0] mcand_q;
    logic [XLEN-1:0]   mplier_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    logic              sgn_a, sgn_b, a_neg, b_neg, is_special;
    logic [XLEN-1:0]   a_mag, b_mag, special_res;

    always_comb begin
        sgn_a = funct3[2] ? ~funct3[0] : (funct3 == F_MULH || funct3 == F_MULHSU);
        sgn_b = funct3[2] ? ~funct3[0] : (funct3 == F_MULH);
        a_neg = sgn_a & rs1_data[XLEN-1];
        b_neg = sgn_b & rs2_data[XLEN-1];
        a_mag = a_neg ? -rs1_data : rs1_data;
        b_mag = b_neg ? -rs2_data : rs2_data;
        is_special = funct3[2] && ((rs2_data == '0) ||
                     (~funct3[0] && rs1_data == INT_MIN && rs2_data == '1));
        if (rs2_data == '0) begin
            special_res = funct3[1] ? rs1_data : '1;
        end else begin
            special_res = funct3[1] ? '0 : INT_MIN;
        end
    end

    // One iteration of the active algorithm; acc holds {remainder, quotient} when dividing.
    logic [XLEN:0]     r_shift, r_diff;
    logic [2*XLEN-1:0] acc_d, prod;
    logic [XLEN-1:0]   quo, rem, final_res;

    always_comb begin
        r_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        r_diff  = r_shift - {1'b0, mcand_q[XLEN-1:0]};
        if (op_q[2]) begin
            if (!r_diff[XLEN]) begin
                acc_d = {r_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
            end else begin
                acc_d = {r_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
        end
        prod = neg_q ? -acc_d : acc_d;
        quo  = neg_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        rem  = rneg_q ? -acc_d[2*XLEN-1:XLEN] : acc_d[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            final_res = op_q[1] ? rem : quo;
        end else begin
            final_res = (op_q == F_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q     <= funct3;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        neg_q    <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        mplier_q <= b_mag;
                        if (funct3[2]) begin
                            acc_q   <= {{XLEN{1'b0}}, a_mag};
                            mcand_q <= {{XLEN{1'b0}}, b_mag};
                        end else begin
                            acc_q   <= '0;
                            mcand_q <= {{XLEN{1'b0}}, a_mag};
                        end
                        if (is_special) begin
                            result_q <= special_res;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    acc_q    <= acc_d;
                    mcand_q  <= op_q[2] ? mcand_q : (mcand_q << 1);
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN-1)) begin
                        result_q <= final_res;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule
